fsm_mem_r_check: RTL and testbench

//  Reader/checker counterpart to the S-memory init writer: on start, sweeps every address
//  of the 256x8 working RAM, reads each byte back through the synchronous read port and

---
 rtl/lab4_pkg.sv | 21 ++
 rtl/rd_lat_pipe.sv | 48 ++++
 rtl/fsm_mem_r_check.sv | 175 +++++++++++++++++
 tb/tb_fsm_mem_r_check.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab4_pkg.sv
// -----------------------------------------------------------------------------
// lab4_pkg
// Shared definitions for the S-memory bring-up blocks: working RAM geometry
// and the state encoding of the read-back checker.
// -----------------------------------------------------------------------------
package lab4_pkg;

  // Working RAM geometry: 256 x 8, address doubles as the identity pattern.
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  // Checker sequence: IDLE -> READ -> DRAIN -> DONE -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// -----------------------------------------------------------------------------
// rd_lat_pipe
// STAGES-deep shift register carrying {valid, addr} alongside the RAM read
// so each returning byte can be paired with the address that fetched it.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset; flushes every stage
//   i_valid  read issued this cycle
//   i_addr   address issued this cycle
//   o_valid  delayed valid, aligned with RAM read data
//   o_addr   delayed address, aligned with RAM read data
// -----------------------------------------------------------------------------
module rd_lat_pipe #(
  parameter int STAGES = 1,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  logic [STAGES-1:0] r_valid;
  logic [ADDR_W-1:0] r_addr [STAGES];

  // Shift {valid, addr} one stage per clock; reset empties the pipe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        r_addr[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_addr  = r_addr[STAGES-1];

endmodule

// File: rtl/fsm_mem_r_check.sv
// -----------------------------------------------------------------------------
// fsm_mem_r_check
// Read-back checker for the S-memory init pattern. On start it reads every
// RAM address once through the synchronous read port, compares each byte
// with addr ^ PAT_XOR and reports pass, mismatch count and first failing
// address using a 4-phase start/finish handshake.
// Ports:
//   i_clk              clock, rising edge
//   i_rst              synchronous active-high reset
//   i_start            level request, sampled in IDLE
//   i_rd_data          RAM read data, valid RD_LAT clocks after the address
//   o_rd_en            read strobe, high for every issued address
//   o_mem_addr         read address
//   o_finish           sweep complete, results valid while high
//   o_pass             1 when the sweep saw zero mismatches
//   o_err_count        number of mismatching addresses (0..2**ADDR_W)
//   o_first_err_addr   address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module fsm_mem_r_check #(
  parameter int                ADDR_W  = lab4_pkg::ADDR_W,
  parameter int                DATA_W  = lab4_pkg::DATA_W,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] PAT_XOR = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_finish,
  output logic              o_pass,
  output logic [ADDR_W:0]   o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  import lab4_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ERR_MAX    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ERR_ONE    = (ADDR_W+1)'(1);
  localparam int                DCNT_W     = $clog2(RD_LAT + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(RD_LAT);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_finish;
  logic                r_pass;
  logic [ADDR_W:0]     r_err_count;
  logic [ADDR_W-1:0]   r_first_err_addr;
  logic [DCNT_W-1:0]   r_drain_cnt;

  logic                w_start_sweep;
  logic                w_pipe_valid;
  logic [ADDR_W-1:0]   w_pipe_addr;
  logic                w_mismatch;

  // Address/valid travel alongside the RAM access so data and address meet.
  rd_lat_pipe #(
    .STAGES (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_lat_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_rd_en),
    .i_addr  (r_addr),
    .o_valid (w_pipe_valid),
    .o_addr  (w_pipe_addr)
  );

  assign w_start_sweep = (r_state == IDLE) && i_start;
  assign w_mismatch    = w_pipe_valid &&
                         (i_rd_data != (DATA_W'(w_pipe_addr) ^ PAT_XOR));

  // Next-state logic for the sweep sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_next = READ;
        else         w_state_next = IDLE;
      end
      READ: begin
        if (r_addr == ADDR_MAX) w_state_next = DRAIN;
        else                    w_state_next = READ;
      end
      // DRAIN lasts RD_LAT+1 clocks: RD_LAT for the last read to return and
      // one more for its compare to land in err_count before pass is taken.
      DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) w_state_next = DONE;
        else                           w_state_next = DRAIN;
      end
      // Stay here until start drops so a held start cannot re-trigger.
      DONE: begin
        if (!i_start) w_state_next = IDLE;
        else          w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register, read issue, drain timer and result accumulation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_rd_en          <= 1'b0;
      r_addr           <= {ADDR_W{1'b0}};
      r_finish         <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= {(ADDR_W+1){1'b0}};
      r_first_err_addr <= {ADDR_W{1'b0}};
      r_drain_cnt      <= {DCNT_W{1'b0}};
    end else begin
      r_state  <= w_state_next;
      r_rd_en  <= (w_state_next == READ);
      r_finish <= (w_state_next == DONE);

      // The address wraps to 0 on the last read, leaving mem_addr idle at 0.
      if (w_start_sweep) begin
        r_addr <= {ADDR_W{1'b0}};
      end else if (r_state == READ) begin
        r_addr <= r_addr + ADDR_ONE;
      end else begin
        r_addr <= r_addr;
      end

      if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + DCNT_ONE;
      end else begin
        r_drain_cnt <= {DCNT_W{1'b0}};
      end

      // The pipe is empty in IDLE, so clearing here never drops a compare.
      if (w_start_sweep) begin
        r_err_count      <= {(ADDR_W+1){1'b0}};
        r_first_err_addr <= {ADDR_W{1'b0}};
      end else if (w_mismatch) begin
        if (r_err_count != ERR_MAX) begin
          r_err_count <= r_err_count + ERR_ONE;
        end else begin
          r_err_count <= r_err_count;
        end
        if (r_err_count == {(ADDR_W+1){1'b0}}) begin
          r_first_err_addr <= w_pipe_addr;
        end else begin
          r_first_err_addr <= r_first_err_addr;
        end
      end else begin
        r_err_count      <= r_err_count;
        r_first_err_addr <= r_first_err_addr;
      end

      // pass is cleared for the new sweep and only re-evaluated on DONE.
      if (w_start_sweep) begin
        r_pass <= 1'b0;
      end else if (w_state_next == DONE) begin
        r_pass <= (r_err_count == {(ADDR_W+1){1'b0}});
      end else begin
        r_pass <= r_pass;
      end
    end
  end

  assign o_rd_en          = r_rd_en;
  assign o_mem_addr       = r_addr;
  assign o_finish         = r_finish;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_fsm_mem_r_check.sv
// -----------------------------------------------------------------------------
// tb_fsm_mem_r_check
// Directed bench for fsm_mem_r_check. Two instances share the clock and
// reset: u_dut1 with RD_LAT=1 and u_dut2 with RD_LAT=2, each backed by its
// own behavioural synchronous RAM. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_fsm_mem_r_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1;
  logic       start2;
  logic [7:0] rd_data1;
  logic [7:0] rd_data2;
  logic [7:0] rd_q2;
  logic       rd_en1;
  logic       rd_en2;
  logic [7:0] addr1;
  logic [7:0] addr2;
  logic       fin1;
  logic       fin2;
  logic       pass1;
  logic       pass2;
  logic [8:0] err1;
  logic [8:0] err2;
  logic [7:0] ferr1;
  logic [7:0] ferr2;

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt1  = 0;
  int seq_err1 = 0;
  int rd_cnt2  = 0;
  int seq_err2 = 0;
  int edges;

  always #5 clk = ~clk;

  fsm_mem_r_check #(.RD_LAT(1)) u_dut1 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start1),
    .i_rd_data        (rd_data1),
    .o_rd_en          (rd_en1),
    .o_mem_addr       (addr1),
    .o_finish         (fin1),
    .o_pass           (pass1),
    .o_err_count      (err1),
    .o_first_err_addr (ferr1)
  );

  fsm_mem_r_check #(.RD_LAT(2)) u_dut2 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start2),
    .i_rd_data        (rd_data2),
    .o_rd_en          (rd_en2),
    .o_mem_addr       (addr2),
    .o_finish         (fin2),
    .o_pass           (pass2),
    .o_err_count      (err2),
    .o_first_err_addr (ferr2)
  );

  // One-cycle synchronous RAM for the RD_LAT=1 instance.
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem1[addr1];
  end

  // Two-cycle synchronous RAM for the RD_LAT=2 instance.
  always @(posedge clk) begin
    if (rd_en2) rd_q2 <= mem2[addr2];
    rd_data2 <= rd_q2;
  end

  // Count issued reads and flag any address out of 0,1,2,... order.
  always @(negedge clk) begin
    if (rd_en1) begin
      if (addr1 != rd_cnt1[7:0]) seq_err1 = seq_err1 + 1;
      rd_cnt1 = rd_cnt1 + 1;
    end
    if (rd_en2) begin
      if (addr2 != rd_cnt2[7:0]) seq_err2 = seq_err2 + 1;
      rd_cnt2 = rd_cnt2 + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_identity();
    for (int a = 0; a < 256; a++) begin
      mem1[a] = 8'(a);
      mem2[a] = 8'(a);
    end
  endtask

  // Raise start (and drop reset) at a negedge, then count edges from the
  // edge that samples start (edge 0) until finish is seen; -1 on timeout.
  task automatic sweep(input int which, output int n_edges);
    n_edges = -1;
    @(negedge clk);
    rst = 1'b0;
    if (which == 1) begin
      rd_cnt1 = 0; seq_err1 = 0; start1 = 1'b1;
    end else begin
      rd_cnt2 = 0; seq_err2 = 0; start2 = 1'b1;
    end
    for (int n = 0; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n == 0 && which == 1) begin
        check_eq("first_cycle_err_cleared", 32'(err1), 32'd0);
        check_eq("first_cycle_rd_en", 32'(rd_en1), 32'd1);
        check_eq("first_cycle_addr", 32'(addr1), 32'd0);
      end
      if ((which == 1 && fin1) || (which == 2 && fin2)) begin
        n_edges = n;
        break;
      end
    end
  endtask

  task automatic stop(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b0;
    else            start2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    rd_q2  = 8'h00;
    fill_identity();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_en",  32'(rd_en1), 32'd0);
    check_eq("rst_addr",   32'(addr1),  32'd0);
    check_eq("rst_finish", 32'(fin1),   32'd0);
    check_eq("rst_pass",   32'(pass1),  32'd0);
    check_eq("rst_err",    32'(err1),   32'd0);
    check_eq("rst_ferr",   32'(ferr1),  32'd0);
    check_eq("rst2_finish", 32'(fin2),  32'd0);

    // 1: clean RAM
    sweep(1, edges);
    check_eq("t1_finish_edge", 32'(edges), 32'd258);
    check_eq("t1_reads", 32'(rd_cnt1), 32'd256);
    check_eq("t1_addr_order", 32'(seq_err1), 32'd0);
    check_eq("t1_pass", 32'(pass1), 32'd1);
    check_eq("t1_err", 32'(err1), 32'd0);
    check_eq("t1_ferr", 32'(ferr1), 32'd0);
    stop(1);
    check_eq("t1_finish_drop", 32'(fin1), 32'd0);
    check_eq("t1_pass_held", 32'(pass1), 32'd1);

    // 2: single corrupt byte
    mem1[8'h37] = 8'h00;
    sweep(1, edges);
    check_eq("t2_finish_edge", 32'(edges), 32'd258);
    check_eq("t2_pass", 32'(pass1), 32'd0);
    check_eq("t2_err", 32'(err1), 32'd1);
    check_eq("t2_ferr", 32'(ferr1), 32'h37);
    stop(1);
    fill_identity();

    // 3: both boundary addresses corrupt
    mem1[8'h00] = 8'hFF;
    mem1[8'hFF] = 8'h00;
    sweep(1, edges);
    check_eq("t3_finish_edge", 32'(edges), 32'd258);
    check_eq("t3_err", 32'(err1), 32'd2);
    check_eq("t3_ferr", 32'(ferr1), 32'h00);
    check_eq("t3_pass", 32'(pass1), 32'd0);

    // 5: start held past finish, then release and restart
    repeat (100) @(posedge clk);
    #1;
    check_eq("t5_finish_held", 32'(fin1), 32'd1);
    check_eq("t5_no_extra_reads", 32'(rd_cnt1), 32'd256);
    stop(1);
    check_eq("t5_finish_drop", 32'(fin1), 32'd0);
    check_eq("t5_err_held_idle", 32'(err1), 32'd2);
    check_eq("t5_pass_held_idle", 32'(pass1), 32'd0);
    fill_identity();
    sweep(1, edges);
    check_eq("t5_finish_edge", 32'(edges), 32'd258);
    check_eq("t5_pass", 32'(pass1), 32'd1);
    stop(1);

    // 4: reset in the middle of a sweep, start kept high
    mem1[8'h10] = 8'h11;
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (addr1 == 8'h80) break;
    end
    check_eq("t4_reach_80", 32'(addr1), 32'h80);
    check_eq("t4_err_before_rst", 32'(err1), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t4_rd_en", 32'(rd_en1), 32'd0);
    check_eq("t4_addr", 32'(addr1), 32'd0);
    check_eq("t4_finish", 32'(fin1), 32'd0);
    check_eq("t4_pass", 32'(pass1), 32'd0);
    check_eq("t4_err", 32'(err1), 32'd0);
    check_eq("t4_ferr", 32'(ferr1), 32'd0);
    fill_identity();
    sweep(1, edges);
    check_eq("t4_finish_edge", 32'(edges), 32'd258);
    check_eq("t4_reads", 32'(rd_cnt1), 32'd256);
    check_eq("t4_addr_order", 32'(seq_err1), 32'd0);
    check_eq("t4_pass", 32'(pass1), 32'd1);
    stop(1);

    // 6: RD_LAT=2 instance, clean then corrupt last address
    sweep(2, edges);
    check_eq("t6_finish_edge", 32'(edges), 32'd259);
    check_eq("t6_reads", 32'(rd_cnt2), 32'd256);
    check_eq("t6_addr_order", 32'(seq_err2), 32'd0);
    check_eq("t6_pass", 32'(pass2), 32'd1);
    stop(2);
    mem2[8'hFF] = 8'h00;
    sweep(2, edges);
    check_eq("t6c_finish_edge", 32'(edges), 32'd259);
    check_eq("t6c_ferr", 32'(ferr2), 32'hFF);
    check_eq("t6c_err", 32'(err2), 32'd1);
    check_eq("t6c_pass", 32'(pass2), 32'd0);
    stop(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
